// File: rtl/btn_pkg.sv
// Shared types and constants for the push-button debounce front-end.
// Channel FSM states plus default and simulation qualification lengths.
package btn_pkg;

    typedef enum logic [1:0] {
        ST_LOW,
        WAIT_HIGH,
        ST_HIGH,
        WAIT_LOW
    } btn_state_t;

    // 20 ms at 50 MHz
    localparam int DEFAULT_DEBOUNCE_CYCLES = 1_000_000;
    localparam int SIM_DEBOUNCE_CYCLES     = 4;

endpackage

// File: rtl/btn_debounce_if.sv
// Pad-side bundle: raw button levels in, clean levels and edge pulses out.
// The debouncer is the slave; pad/stimulus side is the master.
interface btn_debounce_if #(
    parameter int N_BTN = 4
);

    logic [N_BTN-1:0] btn_raw;
    logic [N_BTN-1:0] btn_out;
    logic [N_BTN-1:0] press_pulse;
    logic [N_BTN-1:0] release_pulse;

    modport master (
        output btn_raw,
        input  btn_out,
        input  press_pulse,
        input  release_pulse
    );

    modport slave (
        input  btn_raw,
        output btn_out,
        output press_pulse,
        output release_pulse
    );

endinterface

// File: rtl/btn_debounce_ch.sv
// One button channel: 2-flop synchroniser, qualify FSM, counter, pulses.
// A new level is accepted after DEBOUNCE_CYCLES identical samples.
module btn_debounce_ch
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic pclk,
    input  logic preset_n,
    input  logic raw,
    output logic level,
    output logic press_pulse,
    output logic release_pulse
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    generate
        if (DEBOUNCE_CYCLES < 2) begin : g_bad_len
            $error("btn_debounce_ch: DEBOUNCE_CYCLES must be >= 2");
        end
    endgenerate

    logic             s1;
    logic             s2;
    logic [CNT_W-1:0] cnt;
    btn_state_t       state;

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            s1            <= 1'b0;
            s2            <= 1'b0;
            cnt           <= '0;
            state         <= ST_LOW;
            level         <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            s1            <= raw;
            s2            <= s1;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            unique case (state)
                ST_LOW: begin
                    if (s2) begin
                        state <= WAIT_HIGH;
                        cnt   <= CNT_W'(1);
                    end
                end
                WAIT_HIGH: begin
                    if (!s2) begin
                        state <= ST_LOW;
                        cnt   <= '0;
                    end else if (cnt == CNT_MAX) begin
                        state       <= ST_HIGH;
                        cnt         <= '0;
                        level       <= 1'b1;
                        press_pulse <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_HIGH: begin
                    if (!s2) begin
                        state <= WAIT_LOW;
                        cnt   <= CNT_W'(1);
                    end
                end
                WAIT_LOW: begin
                    if (s2) begin
                        state <= ST_HIGH;
                        cnt   <= '0;
                    end else if (cnt == CNT_MAX) begin
                        state         <= ST_LOW;
                        cnt           <= '0;
                        level         <= 1'b0;
                        release_pulse <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= ST_LOW;
                    cnt   <= '0;
                    level <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/btn_debounce.sv
// Debounce front-end for N_BTN board buttons feeding the APB sampler.
// Channels are identical and fully independent.
module btn_debounce
    import btn_pkg::*;
#(
    parameter int N_BTN           = 4,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic          pclk,
    input  logic          preset_n,
    btn_debounce_if.slave bus
);

    logic [N_BTN-1:0] level;
    logic [N_BTN-1:0] press;
    logic [N_BTN-1:0] rel;

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        btn_debounce_ch #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_ch (
            .pclk          (pclk),
            .preset_n      (preset_n),
            .raw           (bus.btn_raw[i]),
            .level         (level[i]),
            .press_pulse   (press[i]),
            .release_pulse (rel[i])
        );
    end

    assign bus.btn_out       = level;
    assign bus.press_pulse   = press;
    assign bus.release_pulse = rel;

endmodule

// File: tb/tb_btn_debounce.sv
// Directed bench for btn_debounce with a 4-sample qualification window.
// Each check is an immediate assertion against a hand-computed value.
module tb_btn_debounce;
    import btn_pkg::*;

    logic pclk;
    logic preset_n;
    int   vectors;
    int   miscompares;

    btn_debounce_if #(.N_BTN(4)) bus ();

    btn_debounce #(
        .N_BTN           (4),
        .DEBOUNCE_CYCLES (SIM_DEBOUNCE_CYCLES)
    ) dut (
        .pclk     (pclk),
        .preset_n (preset_n),
        .bus      (bus.slave)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    task automatic tick(input int n);
        repeat (n) @(posedge pclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] obs,
                       input logic [3:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [3:0] out_e,
                           input logic [3:0] prs_e, input logic [3:0] rel_e);
        chk({tag, ".out"}, bus.btn_out, out_e);
        chk({tag, ".press"}, bus.press_pulse, prs_e);
        chk({tag, ".release"}, bus.release_pulse, rel_e);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vectors     = 0;
        miscompares = 0;

        // 1. reset with all buttons held
        preset_n    = 1'b0;
        bus.btn_raw = 4'hF;
        tick(3);
        chk_all("rst_hold", 4'h0, 4'h0, 4'h0);
        preset_n = 1'b1;
        tick(5);
        chk_all("rst_e4", 4'h0, 4'h0, 4'h0);
        tick(1);
        chk_all("rst_e5", 4'hF, 4'hF, 4'h0);
        tick(1);
        chk_all("rst_e6", 4'hF, 4'h0, 4'h0);
        bus.btn_raw = 4'h0;
        tick(5);
        chk("rst_rel_e4", bus.btn_out, 4'hF);
        tick(1);
        chk_all("rst_rel_e5", 4'h0, 4'h0, 4'hF);
        tick(1);
        chk_all("rst_rel_e6", 4'h0, 4'h0, 4'h0);

        // 2. clean press and release on bit 0
        bus.btn_raw = 4'b0001;
        tick(5);
        chk_all("p0_e4", 4'h0, 4'h0, 4'h0);
        tick(1);
        chk_all("p0_e5", 4'b0001, 4'b0001, 4'h0);
        tick(1);
        chk_all("p0_e6", 4'b0001, 4'h0, 4'h0);
        bus.btn_raw = 4'b0000;
        tick(5);
        chk_all("r0_e4", 4'b0001, 4'h0, 4'h0);
        tick(1);
        chk_all("r0_e5", 4'h0, 4'h0, 4'b0001);
        tick(1);
        chk_all("r0_e6", 4'h0, 4'h0, 4'h0);

        // 3. bounce train on bit 1: 3 highs then a low, 40 cycles
        for (int i = 0; i < 40; i++) begin
            bus.btn_raw = ((i % 4) < 3) ? 4'b0010 : 4'b0000;
            tick(1);
            chk_all("bounce", 4'h0, 4'h0, 4'h0);
        end
        bus.btn_raw = 4'b0010;
        tick(5);
        chk_all("b1_e4", 4'h0, 4'h0, 4'h0);
        tick(1);
        chk_all("b1_e5", 4'b0010, 4'b0010, 4'h0);
        bus.btn_raw = 4'b0000;
        tick(6);
        chk_all("b1_rel", 4'h0, 4'h0, 4'b0010);
        tick(1);

        // 4. reset mid-qualification of bit 2, bit 0 already high
        bus.btn_raw = 4'b0001;
        tick(6);
        chk("pre_rst_out", bus.btn_out, 4'b0001);
        bus.btn_raw = 4'b0101;
        tick(4);
        chk("mid_cnt", 4'(dut.g_ch[2].u_ch.cnt), 4'd2);
        preset_n = 1'b0;
        #2;
        chk_all("async_drop", 4'h0, 4'h0, 4'h0);
        chk("rst_cnt", 4'(dut.g_ch[2].u_ch.cnt), 4'd0);
        tick(2);
        preset_n = 1'b1;
        tick(5);
        chk_all("rq_e4", 4'h0, 4'h0, 4'h0);
        tick(1);
        chk_all("rq_e5", 4'b0101, 4'b0101, 4'h0);
        tick(1);
        chk_all("rq_e6", 4'b0101, 4'h0, 4'h0);
        bus.btn_raw = 4'b0000;
        tick(6);
        chk_all("rq_rel", 4'h0, 4'h0, 4'b0101);
        tick(1);

        // 5. independent channels: bits 0,3 together, bit 1 two later
        bus.btn_raw = 4'b1001;
        tick(2);
        bus.btn_raw = 4'b1011;
        tick(4);
        chk_all("ind_a", 4'b1001, 4'b1001, 4'h0);
        tick(1);
        chk_all("ind_gap", 4'b1001, 4'h0, 4'h0);
        tick(1);
        chk_all("ind_b", 4'b1011, 4'b0010, 4'h0);
        tick(2);

        // 6. 3-cycle low glitch on held bit 3
        for (int i = 0; i < 10; i++) begin
            bus.btn_raw = (i < 3) ? 4'b0011 : 4'b1011;
            tick(1);
            chk_all("glitch", 4'b1011, 4'h0, 4'h0);
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/btn_debounce.md
# btn_debounce

Upstream conditioning stage for the board push-buttons: synchronises each raw, asynchronous button input into the `pclk` domain and suppresses contact bounce. It produces a clean level per button that drives the `buttons` input of the APB button sampler, plus single-cycle press and release pulses for interrupt or event logic. It has no bus interface and is purely a clocked front-end between the pads and the APB peripheral.

## Interface
Parameters:
- `N_BTN`, default 4: number of independent button channels.
- `DEBOUNCE_CYCLES`, default 1_000_000 (20 ms at 50 MHz): consecutive identical synchronised samples required to accept a new level. Legal range is 2 or more; elaboration fails below 2.
- `CNT_W`, default `$clog2(DEBOUNCE_CYCLES)`: counter width, derived and not overridden.

Ports:
- `pclk` input, 1 bit: single system clock. All flops run on the rising edge.
- `preset_n` input, 1 bit: reset, asynchronous assert, active-low.
- `btn_raw` input, `N_BTN` bits: raw pad levels, asynchronous, 1 = pressed.
- `btn_out` output, `N_BTN` bits: debounced level. Connects to the sampler `buttons` input.
- `press_pulse` output, `N_BTN` bits: 1-cycle pulse when `btn_out[i]` goes 0→1.
- `release_pulse` output, `N_BTN` bits: 1-cycle pulse when `btn_out[i]` goes 1→0.

## Operation
- Each channel is independent and identical, with no cross-channel interaction.
- Synchroniser: 2 flops per channel (`raw` → `s1` → `s2`). The FSM sees only `s2`.
- Per-channel FSM, states `ST_LOW`, `WAIT_HIGH`, `ST_HIGH`, `WAIT_LOW`:
  - `ST_LOW`: if `s2` = 1, go to `WAIT_HIGH` with `cnt` = 1. Otherwise stay.
  - `WAIT_HIGH`:
    - `s2` = 0: return to `ST_LOW`, `cnt` = 0, no pulse.
    - `s2` = 1 and `cnt` = `DEBOUNCE_CYCLES`-1: go to `ST_HIGH`, `cnt` = 0, set `btn_out` = 1, pulse `press_pulse`.
    - Otherwise: `cnt`++.
  - `ST_HIGH` and `WAIT_LOW` mirror the above with polarities inverted; the release path pulses `release_pulse`.
- `btn_out` is registered and equals 1 exactly in `ST_HIGH` and `WAIT_LOW`.
- Pulses are registered and asserted for exactly one cycle, in the same cycle `btn_out` changes.
- Counter arithmetic:
  - Unsigned, `CNT_W` bits.
  - Never exceeds `DEBOUNCE_CYCLES`-1, so it cannot wrap.
  - Cleared on every return to a stable state.
- Any mismatching sample during a WAIT state restarts qualification from zero. A bounce train therefore never changes `btn_out` unless the level is held for `DEBOUNCE_CYCLES` consecutive samples.
- Reset, asserted at any time including mid-qualification:
  - Sync flops, `cnt`, `btn_out`, `press_pulse` and `release_pulse` all go to 0; state goes to `ST_LOW`. Outputs drop asynchronously.
  - After deassertion, a button still held is treated as a new press: full qualification runs and `press_pulse` fires.

## Timing
- Reset values: all outputs 0.
- Press latency: if `btn_raw[i]` rises before edge E0 and then stays stable, `btn_out[i]` and `press_pulse[i]` become 1 after edge E0 + 1 + `DEBOUNCE_CYCLES`.
- Release latency: identical.
- Minimum accepted pulse width is `DEBOUNCE_CYCLES` cycles of `s2`. Shorter pulses are filtered completely.
- Consecutive opposite events on one channel are spaced at least `DEBOUNCE_CYCLES` cycles apart.
- Simultaneous events on different channels are independent; multiple pulse bits may be high in the same cycle.
- Downstream sampler: adds one further register stage, so bus-visible latency is the above plus 1.

## Structure
- Package `btn_pkg` contains:
  - the `btn_state_t` enum (`ST_LOW`, `WAIT_HIGH`, `ST_HIGH`, `WAIT_LOW`);
  - the default `DEBOUNCE_CYCLES` constant;
  - a `SIM_DEBOUNCE_CYCLES` = 4 constant for benches.
- Sub-module `btn_debounce_ch` contains one channel: the synchroniser, FSM, counter and pulse generation.
- Top `btn_debounce` instantiates `N_BTN` copies with a generate loop.

## Test plan
Run with `DEBOUNCE_CYCLES` = 4.
1. Reset: hold `preset_n` = 0 with `btn_raw` = 4'hF. Expect `btn_out`, `press_pulse` and `release_pulse` all 0. After release, expect `btn_out` = 4'hF at edge 5 after the first sampling edge, and `press_pulse` = 4'hF for 1 cycle.
2. Clean press and release on bit 0: raise before E0 and hold. Expect `btn_out[0]` = 1 after E0+5, with a 1-cycle `press_pulse[0]`. Drop and hold, and expect the mirror response with `release_pulse[0]`.
3. Bounce filter: bit 1 toggles 1,1,1,0 repeatedly (3-cycle highs) for 40 cycles. Expect `btn_out[1]` = 0 throughout and no pulses. Then hold high, and expect acceptance exactly 5 edges after the final rise.
4. Reset mid-qualification: assert `preset_n` while bit 2 is in `WAIT_HIGH` with `cnt` = 2, keeping raw high. Expect `cnt` to restart from 0 after deassertion, and `btn_out[2]` to rise 5 edges after the first post-reset sampling edge.
5. Independence: press bits 0 and 3 on the same edge and bit 1 two cycles later. Expect `press_pulse` = 4'b1001 in one cycle and 4'b0010 two cycles later.
6. Glitch during held state: with bit 3 stable high, pull raw low for 3 cycles. Expect `btn_out[3]` to stay 1 and `release_pulse[3]` to stay 0.
